// File: rtl/num_pkg.sv
// Shared types for the sequential add/sub/mul ALU.
package num_pkg;

    // Run-time operation select carried on i_op.
    typedef enum logic [1:0] {
        NUM_ADD = 2'd0,
        NUM_SUB = 2'd1,
        NUM_MUL = 2'd2,
        NUM_RSV = 2'd3
    } num_op_t;

    // Top-level control states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } num_state_t;

endpackage

// File: rtl/num_seq_mul.sv
// Unsigned iterative shift-add multiplier.
// i_start loads the operands; one multiplier bit is consumed per cycle, LSB first, for WIDTH
// cycles. o_done strobes during the final step and o_prod carries the finished 2*WIDTH
// product in that same cycle, so the caller can register it on the last step's edge.
module num_seq_mul
    import num_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_prod
);

    localparam int CntW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;

    // Accumulator value after conditionally adding the shifted multiplicand.
    always_comb begin
        step_acc = acc_q;
        if (mplier_q[0]) begin
            step_acc = acc_q + mcand_q;
        end
    end

    // Load on start, otherwise advance one multiplier bit per cycle while busy.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (i_start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, i_a};
            mplier_d = i_b;
            cnt_d    = CntW'(WIDTH);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Engine state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = busy_q && (cnt_q == CntW'(1));
    assign o_prod = step_acc;

endmodule

// File: rtl/num_alu_seq.sv
// Sequential ALU: add/sub in one cycle, multiply through an iterative shift-add engine.
// Valid/ready handshake on operands and result. Add/sub/reserved results are computed from
// the operands at accept time and registered directly; multiply captures only the sign of
// the product and hands magnitudes to num_seq_mul.
// Optional feature: define NUM_ALU_OVF_EN to add the registered o_ovf overflow output.
module num_alu_seq
    import num_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
`ifdef NUM_ALU_OVF_EN
    output logic             o_ovf,
`endif
    output logic [WIDTH-1:0] o_res
);

    num_state_t         state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               neg_q, neg_d;

    num_op_t            op_in;
    logic               accept;
    logic               mul_start;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] prod_s;

    assign op_in     = num_op_t'(i_op);
    assign accept    = i_valid && (state_q == S_IDLE);
    assign mul_start = accept && (op_in == NUM_MUL);
    // The extra top bit is the carry (add) or borrow (sub) out of WIDTH bits.
    assign sum       = {1'b0, i_a} + {1'b0, i_b};
    assign diff      = {1'b0, i_a} - {1'b0, i_b};
    assign prod_s    = neg_q ? -mul_prod : mul_prod;

    // Operand magnitudes for the unsigned engine; |MIN| still fits in WIDTH bits.
    always_comb begin
        mag_a = i_a;
        mag_b = i_b;
        if (SIGNED && i_a[WIDTH-1]) begin
            mag_a = -i_a;
        end
        if (SIGNED && i_b[WIDTH-1]) begin
            mag_b = -i_b;
        end
    end

    num_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (mul_start),
        .i_a     (mag_a),
        .i_b     (mag_b),
        .o_busy  (mul_busy),
        .o_done  (mul_done),
        .o_prod  (mul_prod)
    );

    // Control FSM and result capture.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        neg_d   = neg_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (op_in)
                        NUM_ADD: begin
                            res_d   = sum[WIDTH-1:0];
                            state_d = S_DONE;
                        end
                        NUM_SUB: begin
                            res_d   = diff[WIDTH-1:0];
                            state_d = S_DONE;
                        end
                        NUM_MUL: begin
                            neg_d   = SIGNED && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                            state_d = S_MUL;
                        end
                        NUM_RSV: begin
                            res_d   = '0;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    res_d   = prod_s[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
        end
    end

`ifdef NUM_ALU_OVF_EN
    logic ovf_q, ovf_d;
    logic add_ovf, sub_ovf, mul_ovf;
    logic unused_busy;

    assign unused_busy = mul_busy;

    // Overflow rules per operation and signedness.
    always_comb begin
        if (SIGNED) begin
            add_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (sum[WIDTH-1] != i_a[WIDTH-1]);
            sub_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (diff[WIDTH-1] != i_a[WIDTH-1]);
            // Top WIDTH+1 bits must be a pure sign extension of the kept result.
            mul_ovf = !(&prod_s[2*WIDTH-1:WIDTH-1]) && (|prod_s[2*WIDTH-1:WIDTH-1]);
        end else begin
            add_ovf = sum[WIDTH];
            sub_ovf = diff[WIDTH];
            mul_ovf = |mul_prod[2*WIDTH-1:WIDTH];
        end
    end

    // Overflow flag is registered on the same edge as the result it describes.
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            unique case (op_in)
                NUM_ADD: ovf_d = add_ovf;
                NUM_SUB: ovf_d = sub_ovf;
                NUM_MUL: ovf_d = ovf_q;
                NUM_RSV: ovf_d = 1'b0;
            endcase
        end else if ((state_q == S_MUL) && mul_done) begin
            ovf_d = mul_ovf;
        end
    end

    // Overflow register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;
`else
    // Carry/borrow bits and the upper product half only feed the overflow flag.
    logic unused_hi;
    assign unused_hi = ^{sum[WIDTH], diff[WIDTH], prod_s[2*WIDTH-1:WIDTH], mul_busy};
`endif

    assign o_ready = (state_q == S_IDLE);
    assign o_valid = (state_q == S_DONE);
    assign o_res   = res_q;

endmodule

// File: doc/num_alu_seq.md
Name: num_alu_seq

Overview:
- Parametrised successor to the fixed-width combinational plus/minus/mul family.
- A single block serves any width and signedness and selects add, sub or mul at run time.
- Add and sub finish in 1 cycle. Mul uses an iterative shift-add engine over WIDTH cycles.
- Valid/ready handshake on both input and output. Sits between operand producers and result consumers in datapaths that cannot afford a full combinational multiplier.

Parameters:
- WIDTH, 8: operand/result width in bits, legal range 2..64.
- SIGNED, 0: 1 = two's-complement operands; 0 = unsigned.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  operand transfer request
- o_ready  out  1  block can accept operands
- i_op  in  2  0 = add, 1 = sub, 2 = mul, 3 = reserved
- i_a  in  WIDTH  operand A
- i_b  in  WIDTH  operand B
- o_valid  out  1  result available
- i_ready  in  1  consumer accepts result
- o_res  out  WIDTH  result, modulo 2^WIDTH
- o_ovf  out  1  overflow flag; present only with NUM_ALU_OVF_EN

Behaviour:
- Reset values:
  - state = IDLE, so o_ready = 1.
  - o_valid = 0, o_res = 0, o_ovf = 0.
  - Input transfers are ignored while i_rst is high.
- State machine: IDLE, MUL, DONE. o_ready = (state == IDLE). o_valid = (state == DONE).
- IDLE, on i_valid & o_ready: capture i_op, i_a and i_b.
  - op 0/1/3: go to DONE next cycle.
  - op 2: go to MUL.
- Result in DONE:
  - add: o_res = A + B.
  - sub: o_res = A - B.
  - op 3: o_res = 0, o_ovf = 0.
  - All results truncated to WIDTH bits (wrap-around).
  - Latency: accept at cycle t gives o_valid at t+1.
- MUL:
  - Uses 2*WIDTH-bit accumulator. One multiplier bit per cycle, LSB first, for exactly WIDTH cycles, then DONE.
  - Latency: accept at t gives o_valid at t+WIDTH+1.
  - If SIGNED: multiply operand magnitudes (|MIN| fits in WIDTH unsigned bits). Negate the 2W product if operand signs differ.
  - o_res = low WIDTH bits of the product, which is bit-identical to a truncated combinational multiply.
- DONE:
  - o_res (and o_ovf) hold stable while o_valid = 1 and i_ready = 0.
  - On i_ready: return to IDLE. The next accept is possible the following cycle, giving a throughput of one op per 2 cycles minimum.
- Asynchronous reset mid-MUL or mid-DONE: result discarded immediately; all outputs go to reset values.
- i_op, i_a and i_b are don't-care when not being accepted.

Optional Feature:
- NUM_ALU_OVF_EN defined: o_ovf is present and registered alongside o_res.
  - Unsigned:
    - add: carry out.
    - sub: borrow (A < B).
    - mul: upper WIDTH bits of product nonzero.
  - Signed:
    - add/sub: operand signs match the rule and the result sign differs.
    - mul: upper WIDTH+1 product bits not all equal.
- Not defined: no o_ovf port. Carry/overflow logic is absent; o_res is unchanged.

Decomposition:
- Package num_pkg:
  - typedef enum logic [1:0] num_op_t (NUM_ADD, NUM_SUB, NUM_MUL, NUM_RSV).
  - typedef enum state type (S_IDLE, S_MUL, S_DONE).
- Sub-module num_seq_mul:
  - Parametrised on WIDTH.
  - start/busy/done interface.
  - Unsigned iterative multiplier returning the 2W product.
  - Sign handling and overflow stay in the top level.

Test Plan:
- WIDTH=8, SIGNED=1: add 100+50 -> o_res=8'h96 one cycle after accept; o_ovf=1 (with EN).
- WIDTH=8, SIGNED=0: sub 3-5 -> o_res=8'hFE, o_ovf=1; sub 5-3 -> 8'h02, o_ovf=0.
- WIDTH=8, SIGNED=0: mul 16*17 -> o_res=8'h10, o_ovf=1; o_valid rises exactly 9 cycles after accept; o_ready=0 throughout.
- WIDTH=8, SIGNED=1:
  - mul -3*7 -> o_res=8'hEB, o_ovf=0.
  - mul -128*-1 -> o_res=8'h80, o_ovf=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_res/o_ovf stable, o_ready=0, i_valid ignored. i_ready=1 -> IDLE next cycle, o_ready=1.
- Assert i_rst 4 cycles into a mul -> o_valid=0, o_res=0, o_ready=1 immediately. A new add 1+1 after release -> o_res=2.
